ram_io_responder: RTL

Responder end of the CPU's byte-wide memory bus (`mem_a`/`mem_wr`/`mem_dout` in, `mem_din`/`io_buffer_full` out), driven by the memory controller inside `cpu`. Implements the 128 KB RAM with one-cycle read latency and the memory-mapped I/O window at 0x30000. That window covers the UART RX/TX byte streams, the running cycle counter and the program-stop register. Sits beside `cpu` in the simulation/FPGA top and replaces an ad-hoc RAM+UART glue.

---
 rtl/io_map_pkg.sv | 19 +
 rtl/byte_fifo.sv | 54 +++++
 rtl/ram_io_responder.sv | 133 +++++++++++++
 3 files changed

// File: rtl/io_map_pkg.sv
// Shared I/O map for the CPU memory bus: decoded addresses, select bits and the byte type.
package io_map_pkg;

  typedef logic [7:0] byte_t;

  localparam logic [17:0] IO_UART_ADDR = 18'h30000;
  localparam logic [17:0] IO_CLK_ADDR  = 18'h30004;
  localparam logic [1:0]  IO_SEL       = 2'b11;

  typedef enum logic [1:0] {IO_NONE, IO_UART, IO_CLK} io_dev_e;

  // The clock device answers on a 4-byte window so a dword can be read bytewise.
  function automatic io_dev_e io_decode(input logic [17:0] addr);
    if (addr == IO_UART_ADDR) return IO_UART;
    if (addr[17:2] == IO_CLK_ADDR[17:2]) return IO_CLK;
    return IO_NONE;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Byte FIFO with a combinational head; a push into a full FIFO lands if a pop happens in the same cycle.
module byte_fifo
  import io_map_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   push,
  input  logic                   pop,
  input  byte_t                  din,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output byte_t                  head
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [PW:0]   CNT_ONE = (PW + 1)'(1);
  localparam logic [PW:0]   CNT_MAX = (PW + 1)'(DEPTH);

  byte_t         mem [DEPTH];
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [PW:0]   count_reg;
  logic          pop_ok;
  logic          push_ok;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CNT_MAX);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign count   = count_reg;
  assign head    = empty ? '0 : mem[rd_ptr_reg];

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      if (push_ok && !pop_ok)      count_reg <= count_reg + CNT_ONE;
      else if (pop_ok && !push_ok) count_reg <= count_reg - CNT_ONE;
    end
  end

  always_ff @(posedge clk_in) begin
    if (push_ok) mem[wr_ptr_reg] <= din;
  end

endmodule

// File: rtl/ram_io_responder.sv
// Responder for the CPU byte bus: 128 KB RAM plus the UART / cycle-counter / stop window at 0x30000.
module ram_io_responder
  import io_map_pkg::*;
#(
  parameter int ADDR_WIDTH  = 17,
  parameter int FIFO_DEPTH  = 16,
  parameter int FULL_MARGIN = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] mem_a,
  input  logic        mem_wr,
  input  logic [7:0]  mem_dout,
  output logic [7:0]  mem_din,
  output logic        io_buffer_full,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        program_stop,
  output logic        tx_overflow
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] MARGIN_C = CW'(FULL_MARGIN);

  logic [17:0]           io_addr;
  logic                  is_io;
  io_dev_e               dev;
  logic                  uart_rd, clk_rd, tx_push, stop_wr, ram_we, tx_drop;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic                  unused_addr_bits;

  assign io_addr  = mem_a[17:0];
  assign ram_addr = mem_a[ADDR_WIDTH-1:0];
  assign is_io    = (io_addr[17:16] == IO_SEL);
  assign dev      = is_io ? io_decode(io_addr) : IO_NONE;
  assign uart_rd  = (dev == IO_UART) && !mem_wr;
  assign clk_rd   = (dev == IO_CLK) && !mem_wr;
  assign tx_push  = (dev == IO_UART) && mem_wr && (mem_dout != 8'h00);
  assign stop_wr  = is_io && mem_wr && (io_addr == IO_CLK_ADDR);
  assign ram_we   = mem_wr && !is_io;
  assign unused_addr_bits = &{1'b0, mem_a[31:18]};

  byte_t ram [2**ADDR_WIDTH];
  byte_t ram_rd_reg;

  always_ff @(posedge clk_in) begin
    if (ram_we) ram[ram_addr] <= mem_dout;
    ram_rd_reg <= ram[ram_addr];
  end

  logic          rx_full, rx_empty, tx_full, tx_empty;
  logic [CW-1:0] rx_count_unused, tx_count;
  byte_t         rx_head, tx_head;

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .push   (rx_valid && rx_ready),
    .pop    (uart_rd),
    .din    (rx_data),
    .full   (rx_full),
    .empty  (rx_empty),
    .count  (rx_count_unused),
    .head   (rx_head)
  );

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .push   (tx_push),
    .pop    (tx_ready),
    .din    (mem_dout),
    .full   (tx_full),
    .empty  (tx_empty),
    .count  (tx_count),
    .head   (tx_head)
  );

  assign rx_ready = !rx_full;
  assign tx_valid = !tx_empty;
  assign tx_data  = tx_head;
  // A full TX FIFO is never empty, so tx_ready alone tells whether a slot frees up this cycle.
  assign tx_drop  = tx_push && tx_full && !tx_ready;

  logic [31:0] counter_reg, snapshot_reg;
  byte_t       snap_bytes [4];
  byte_t       io_rd_reg, io_rd_next;
  logic        ram_sel_reg, program_stop_reg, tx_overflow_reg, io_buffer_full_reg;

  for (genvar gi = 0; gi < 4; gi++) begin : g_snap
    assign snap_bytes[gi] = snapshot_reg[8*gi +: 8];
  end

  // Byte 0 returns the live counter while it is captured, so all four bytes belong to one sample.
  always_comb begin
    io_rd_next = '0;
    if (uart_rd)
      io_rd_next = rx_empty ? 8'h00 : rx_head;
    else if (clk_rd)
      io_rd_next = (io_addr[1:0] == 2'b00) ? counter_reg[7:0] : snap_bytes[io_addr[1:0]];
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      counter_reg        <= '0;
      snapshot_reg       <= '0;
      io_rd_reg          <= '0;
      ram_sel_reg        <= 1'b0;
      program_stop_reg   <= 1'b0;
      tx_overflow_reg    <= 1'b0;
      io_buffer_full_reg <= 1'b0;
    end else begin
      counter_reg        <= counter_reg + 32'd1;
      io_rd_reg          <= io_rd_next;
      ram_sel_reg        <= !mem_wr && !is_io;
      io_buffer_full_reg <= (DEPTH_C - tx_count) <= MARGIN_C;
      if (clk_rd && io_addr[1:0] == 2'b00) snapshot_reg <= counter_reg;
      if (stop_wr) program_stop_reg <= 1'b1;
      if (tx_drop) tx_overflow_reg <= 1'b1;
    end
  end

  assign mem_din        = ram_sel_reg ? ram_rd_reg : io_rd_reg;
  assign io_buffer_full = io_buffer_full_reg;
  assign program_stop   = program_stop_reg;
  assign tx_overflow    = tx_overflow_reg;

endmodule
